// File: rtl/noc_common_clk_gate_ctrl_pkg.sv
// Shared types and default parameters for the NoC clock-gate controller.
package noc_common_clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StGated = 2'd2,
    StWake  = 2'd3
  } state_e;

  localparam int unsigned NumReqDef   = 4;
  localparam int unsigned IdleCntWDef = 8;
  localparam int unsigned WakeLatDef  = 2;
  localparam int unsigned StatsWDef   = 32;

endpackage

// File: rtl/noc_common_clk_gate_stats.sv
// Saturating gate-entry and gated-cycle counters with synchronous clear.
module noc_common_clk_gate_stats #(
  parameter int unsigned StatsW = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_gate_evt,
  input  logic              i_gated,
  output logic [StatsW-1:0] o_gate_events,
  output logic [StatsW-1:0] o_gated_cycles
);

  logic [StatsW-1:0] events_q, events_d;
  logic [StatsW-1:0] cycles_q, cycles_d;

  always_comb begin
    events_d = events_q;
    cycles_d = cycles_q;
    if (i_clr) begin
      events_d = '0;
      cycles_d = '0;
    end else begin
      if (i_gate_evt && (events_q != '1)) events_d = events_q + StatsW'(1);
      if (i_gated && (cycles_q != '1))    cycles_d = cycles_q + StatsW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      events_q <= '0;
      cycles_q <= '0;
    end else begin
      events_q <= events_d;
      cycles_q <= cycles_d;
    end
  end

  assign o_gate_events  = events_q;
  assign o_gated_cycles = cycles_q;

endmodule

// File: rtl/noc_common_clk_gate_ctrl.sv
// Idle-driven clock-gate controller; NOC_COMMON_CLK_GATE_STATS_EN adds the
// gate-event and gated-cycle statistics counters.
module noc_common_clk_gate_ctrl
  import noc_common_clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned NumReq   = NumReqDef,
  parameter int unsigned IdleCntW = IdleCntWDef,
  parameter int unsigned WakeLat  = WakeLatDef,
  parameter int unsigned StatsW   = StatsWDef
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic [IdleCntW-1:0] i_idle_thresh,
  input  logic                i_test_en,
  input  logic [NumReq-1:0]   i_busy,
  input  logic [NumReq-1:0]   i_wake_req,
  output logic [NumReq-1:0]   o_wake_ack,
  output logic                o_clk_en,
  output logic                o_gated,
  input  logic                i_stats_clr,
  output logic [StatsW-1:0]   o_gate_events,
  output logic [StatsW-1:0]   o_gated_cycles
);

  localparam int unsigned WakeCntW = (WakeLat > 1) ? $clog2(WakeLat) : 1;

  state_e              state_q, state_d;
  logic [IdleCntW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WakeCntW-1:0] wake_cnt_q, wake_cnt_d;
  logic                clk_en_q;
  logic                quiet;

  assign quiet = i_enable & ~|i_busy & ~|i_wake_req & ~i_test_en;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      StRun: begin
        if (quiet) begin
          state_d    = StDrain;
          idle_cnt_d = '0;
        end
      end
      StDrain: begin
        if (!quiet) begin
          state_d    = StRun;
          idle_cnt_d = '0;
        end else if (idle_cnt_q >= i_idle_thresh) begin
          state_d = StGated;
        end else if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + IdleCntW'(1);
        end
      end
      StGated: begin
        if (!quiet) begin
          state_d    = StWake;
          wake_cnt_d = '0;
        end
      end
      StWake: begin
        if (wake_cnt_q == WakeCntW'(WakeLat - 1)) state_d = StRun;
        else                                      wake_cnt_d = wake_cnt_q + WakeCntW'(1);
      end
      default: state_d = StWake;
    endcase
  end

  // Gater enable is registered from next state so EN changes glitch-free with the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StWake;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      clk_en_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      clk_en_q   <= (state_d != StGated);
    end
  end

  assign o_clk_en   = clk_en_q;
  assign o_gated    = (state_q == StGated);
  assign o_wake_ack = (state_q == StRun) ? i_wake_req : '0;

`ifdef NOC_COMMON_CLK_GATE_STATS_EN
  noc_common_clk_gate_stats #(
    .StatsW (StatsW)
  ) u_stats (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_clr          (i_stats_clr),
    .i_gate_evt     ((state_q == StDrain) && (state_d == StGated)),
    .i_gated        (state_q == StGated),
    .o_gate_events  (o_gate_events),
    .o_gated_cycles (o_gated_cycles)
  );
`else
  logic unused_stats_clr;
  assign unused_stats_clr = i_stats_clr;
  assign o_gate_events    = '0;
  assign o_gated_cycles   = '0;
`endif

endmodule

// File: tb/tb_noc_common_clk_gate_ctrl.sv
// Directed vector bench for noc_common_clk_gate_ctrl (NumReq=4, WakeLat=2).
module tb_noc_common_clk_gate_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b1;
  logic [7:0]  i_idle_thresh = 8'd5;
  logic        i_test_en = 1'b0;
  logic [3:0]  i_busy = '0;
  logic [3:0]  i_wake_req = '0;
  logic [3:0]  o_wake_ack;
  logic        o_clk_en;
  logic        o_gated;
  logic        i_stats_clr = 1'b0;
  logic [31:0] o_gate_events;
  logic [31:0] o_gated_cycles;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  noc_common_clk_gate_ctrl u_dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_enable       (i_enable),
    .i_idle_thresh  (i_idle_thresh),
    .i_test_en      (i_test_en),
    .i_busy         (i_busy),
    .i_wake_req     (i_wake_req),
    .o_wake_ack     (o_wake_ack),
    .o_clk_en       (o_clk_en),
    .o_gated        (o_gated),
    .i_stats_clr    (i_stats_clr),
    .o_gate_events  (o_gate_events),
    .o_gated_cycles (o_gated_cycles)
  );

  typedef struct packed {
    logic       en;
    logic       te;
    logic [3:0] busy;
    logic [3:0] wake;
    logic [7:0] thr;
    logic       e_clk;
    logic       e_gated;
    logic [3:0] e_ack;
  } vec_t;

  vec_t vecs [18];

  task automatic check_out(input string name, input logic e_clk, input logic e_gated,
                           input logic [3:0] e_ack);
    n_vec++;
    if ({o_clk_en, o_gated, o_wake_ack} !== {e_clk, e_gated, e_ack}) begin
      n_fail++;
      $display("FAIL %s: clk_en/gated/ack = %b/%b/%b, required %b/%b/%b", name,
               o_clk_en, o_gated, o_wake_ack, e_clk, e_gated, e_ack);
    end
  endtask

  task automatic drive(input logic en, input logic te, input logic [3:0] busy,
                       input logic [3:0] wake, input logic [7:0] thr);
    i_enable = en; i_test_en = te; i_busy = busy; i_wake_req = wake; i_idle_thresh = thr;
  endtask

  // One cycle: inputs applied just after the edge, outputs sampled 2 time units later.
  task automatic cyc(input string name, input logic en, input logic te, input logic [3:0] busy,
                     input logic [3:0] wake, input logic [7:0] thr, input logic e_clk,
                     input logic e_gated, input logic [3:0] e_ack);
    @(posedge i_clk); #1;
    drive(en, te, busy, wake, thr);
    #1;
    check_out(name, e_clk, e_gated, e_ack);
  endtask

  // Leaves the DUT in WAKE cycle 0 (first cycle after reset release).
  task automatic do_reset(input logic [3:0] wake, input logic [7:0] thr);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    drive(1'b1, 1'b0, 4'h0, wake, thr);
    #1;
    check_out("rst_async", 1'b1, 1'b0, 4'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    #1;
    check_out("rst_wake0", 1'b1, 1'b0, 4'h0);
  endtask

  // Ends in the first RUN cycle with quiet inputs applied.
  task automatic reset_run(input logic [7:0] thr);
    do_reset(4'h0, thr);
    cyc("rr_wake1", 1, 0, 0, 0, thr, 1, 0, 0);
    cyc("rr_run",   1, 0, 0, 0, thr, 1, 0, 0);
  endtask

  task automatic check_stats(input string name, input logic [31:0] e_ev,
                             input logic [31:0] e_cy);
    n_vec++;
    if (o_gate_events !== e_ev || o_gated_cycles !== e_cy) begin
      n_fail++;
      $display("FAIL %s: events/cycles = %0d/%0d, required %0d/%0d", name,
               o_gate_events, o_gated_cycles, e_ev, e_cy);
    end
  endtask

  // Starts after a RUN cycle with quiet inputs; 10 gated cycles, ends in RUN quiet.
  task automatic episode();
    cyc("ep_drain", 1, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 9; k++) cyc("ep_gated", 1, 0, 0, 0, 0, 0, 1, 0);
    cyc("ep_wake_in", 1, 0, 0, 1, 0, 0, 1, 0);
    cyc("ep_wake0",   1, 0, 0, 1, 0, 1, 0, 0);
    cyc("ep_wake1",   1, 0, 0, 1, 0, 1, 0, 0);
    cyc("ep_ack",     1, 0, 0, 1, 0, 1, 0, 1);
    cyc("ep_run",     1, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    logic [31:0] exp_ev, exp_cy;

    // Thresh=5 quiet from reset, then wake_req[2] in GATED, then wake in DRAIN.
    vecs[0]  = '{1, 0, 4'h0, 4'h0, 8'd5, 1, 0, 4'h0};  // WAKE cnt1
    vecs[1]  = '{1, 0, 4'h0, 4'h0, 8'd5, 1, 0, 4'h0};  // RUN
    for (int i = 2; i < 8; i++) vecs[i] = '{1, 0, 4'h0, 4'h0, 8'd5, 1, 0, 4'h0};  // DRAIN
    vecs[8]  = '{1, 0, 4'h0, 4'h0, 8'd5, 0, 1, 4'h0};  // GATED, 7 after RUN entry
    vecs[9]  = '{1, 0, 4'h0, 4'h0, 8'd5, 0, 1, 4'h0};
    vecs[10] = '{1, 0, 4'h0, 4'h4, 8'd5, 0, 1, 4'h0};  // wake_req[2] at t
    vecs[11] = '{1, 0, 4'h0, 4'h4, 8'd5, 1, 0, 4'h0};  // t+1 clk_en up
    vecs[12] = '{1, 0, 4'h0, 4'h4, 8'd5, 1, 0, 4'h0};
    vecs[13] = '{1, 0, 4'h0, 4'h4, 8'd5, 1, 0, 4'h4};  // t+3 RUN, ack
    vecs[14] = '{1, 0, 4'h0, 4'h0, 8'd5, 1, 0, 4'h0};  // RUN, quiet
    vecs[15] = '{1, 0, 4'h0, 4'h1, 8'd5, 1, 0, 4'h0};  // DRAIN, wake: no ack yet
    vecs[16] = '{1, 0, 4'h0, 4'h1, 8'd5, 1, 0, 4'h1};  // RUN, ack after 1 cycle
    vecs[17] = '{1, 0, 4'h0, 4'h0, 8'd5, 1, 0, 4'h0};

    do_reset(4'h0, 8'd5);
    check_stats("stats_reset", 32'd0, 32'd0);
    for (int i = 0; i < 18; i++) begin
      cyc($sformatf("vec%0d", i), vecs[i].en, vecs[i].te, vecs[i].busy, vecs[i].wake,
          vecs[i].thr, vecs[i].e_clk, vecs[i].e_gated, vecs[i].e_ack);
    end

    // Busy pulse as idle_cnt reaches thresh=3: no gating, gates 5 cycles after busy drops.
    reset_run(8'd3);
    for (int i = 3; i < 6; i++) cyc("bz_drain", 1, 0, 0, 0, 3, 1, 0, 0);
    cyc("bz_pulse", 1, 0, 4'h1, 0, 3, 1, 0, 0);
    for (int i = 7; i < 12; i++) cyc("bz_nogate", 1, 0, 0, 0, 3, 1, 0, 0);
    cyc("bz_gate", 1, 0, 0, 0, 3, 0, 1, 0);

    // i_enable=0 then i_test_en=1 in GATED; wake in first GATED cycle.
    reset_run(8'd0);
    cyc("en_drain", 1, 0, 0, 0, 0, 1, 0, 0);
    cyc("en_off",   0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 5; i < 9; i++) cyc("en_held", 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("en_run_ack", 0, 0, 0, 4'h8, 0, 1, 0, 4'h8);
    cyc("en_back",  1, 0, 0, 0, 0, 1, 0, 0);
    cyc("en_drain2", 1, 0, 0, 0, 0, 1, 0, 0);
    cyc("te_on",    1, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 13; i < 16; i++) cyc("te_held", 1, 1, 0, 0, 0, 1, 0, 0);
    cyc("te_run_ack", 1, 1, 0, 4'h2, 0, 1, 0, 4'h2);
    cyc("te_held2", 1, 1, 0, 0, 0, 1, 0, 0);
    cyc("te_off",   1, 0, 0, 0, 0, 1, 0, 0);
    cyc("fg_drain", 1, 0, 0, 0, 0, 1, 0, 0);
    cyc("fg_gated", 1, 0, 0, 4'h1, 0, 0, 1, 0);
    cyc("fg_wake0", 1, 0, 0, 4'h1, 0, 1, 0, 0);
    cyc("fg_wake1", 1, 0, 0, 4'h1, 0, 1, 0, 0);
    cyc("fg_ack",   1, 0, 0, 4'h1, 0, 1, 0, 4'h1);

    // Live threshold: lowered from 10 to 2 while idle_cnt=4 gates next cycle.
    reset_run(8'd10);
    for (int i = 3; i < 7; i++) cyc("lt_drain", 1, 0, 0, 0, 10, 1, 0, 0);
    cyc("lt_lower", 1, 0, 0, 0, 2, 1, 0, 0);
    cyc("lt_gated", 1, 0, 0, 0, 2, 0, 1, 0);

    // Reset while GATED with all wake requests high.
    do_reset(4'hf, 8'd2);
    cyc("rg_wake1", 1, 0, 0, 4'hf, 2, 1, 0, 4'h0);
    cyc("rg_run",   1, 0, 0, 4'hf, 2, 1, 0, 4'hf);

    // Statistics: three episodes of 10 gated cycles, then clear.
    reset_run(8'd0);
    check_stats("stats_zero", 32'd0, 32'd0);
    for (int e = 0; e < 3; e++) episode();
`ifdef NOC_COMMON_CLK_GATE_STATS_EN
    exp_ev = 32'd3;
    exp_cy = 32'd30;
`else
    exp_ev = 32'd0;
    exp_cy = 32'd0;
`endif
    check_stats("stats_total", exp_ev, exp_cy);
    @(posedge i_clk); #1;
    i_stats_clr = 1'b1;
    drive(1, 0, 0, 4'h1, 0);
    #1;
    check_stats("stats_hold", exp_ev, exp_cy);
    @(posedge i_clk); #1;
    i_stats_clr = 1'b0;
    #1;
    check_stats("stats_clr", 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
